// File: rtl/nsa_pkg.sv
// nsa_pkg: shared nibble width, FSM state encoding and step-count helper for nibble_serial_adder
package nsa_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;
  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction
endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder exposing the carry into bit 3
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);
  logic [3:0] g, p;
  logic c1, c2;
  assign g = a & b;
  assign p = a ^ b;
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder stepping one 4-bit lookahead slice per cycle; NIBBLE_SERIAL_ADDER_OVF_EN adds ovf
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int NIB = nib_count(WIDTH);
  localparam int IW = $clog2(NIB);
  if (WIDTH % NIBBLE_W != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end
  nsa_state_t st, nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic carry, last, s_cout, s_c3;
  logic [NIBBLE_W-1:0] s_sum;
  assign last = idx == IW'(NIB - 1);
  cla4_slice u_slice (
    .a   (a_r[idx*NIBBLE_W +: NIBBLE_W]),
    .b   (b_r[idx*NIBBLE_W +: NIBBLE_W]),
    .cin (carry),
    .sum (s_sum),
    .cout(s_cout),
    .c3  (s_c3)
  );
`ifndef NIBBLE_SERIAL_ADDER_OVF_EN
  logic unused_c3;
  assign unused_c3 = s_c3;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_comb begin
    in_ready = st == IDLE;
    out_valid = st == DONE;
    busy = st != IDLE;
    nxt = (st == IDLE) ? (in_valid ? RUN : IDLE)
        : (st == RUN) ? (last ? DONE : RUN)
        : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      carry <= 1'b0;
      idx <= '0;
      sum <= '0;
      cout <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (st == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
      carry <= cin;
      idx <= '0;
      sum <= '0;
    end else if (st == RUN) begin
      sum[idx*NIBBLE_W +: NIBBLE_W] <= s_sum;
      carry <= s_cout;
      if (last) begin
        cout <= s_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ovf <= s_c3 ^ s_cout;
`endif
      end else idx <= idx + 1'b1;
    end
  end
endmodule
